servo_pwm_multi_slew: RTL
=========================

Name: servo_pwm_multi_slew

Overview:
N-channel hobby-servo PWM generator.
- All channels share one frame counter, so pulses on every channel start in the same cycle.
- Each channel holds its own commanded angle. The angle moves toward its target by at most SLEW_DEG per frame, which gives smooth motion and limits current spikes.
- Pulse geometry is fully parametrised. The block sits between the control FSM, which supplies angles and enables, and the servo output pins.

Parameters:
N_CH, 4, number of servo channels
PERIOD_CYC, 1000000, frame length in clk cycles (20 ms at 50 MHz)
MIN_WIDTH, 30000, pulse width in cycles at angle 0
STEP_CYC, 500, pulse-width cycles added per degree
MAX_ANGLE, 180, upper clamp for target angle
SLEW_DEG, 2, max degree change of the current angle per frame; 0 = no limit (jump directly to target)
HOME_ANGLE, 90, current angle loaded at reset
CNT_W, 20, counter/width bit width; must hold PERIOD_CYC-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
angle_in  in  8*N_CH  packed target angles; channel i uses bits [8i+7:8i]
ch_en  in  N_CH  per-channel drive enable
servo_pwm  out  N_CH  PWM outputs, registered
frame_start  out  1  one-cycle pulse in the first cycle of each frame
at_target  out  N_CH  per channel: current angle equals clamped target, registered

Behaviour:
- Reset (async, immediate, valid mid-pulse):
  - cnt=0; every cur_angle=HOME_ANGLE; width_lat=MIN_WIDTH+HOME_ANGLE*STEP_CYC.
  - en_lat=0; servo_pwm=0; frame_start=0; at_target=0.
- Frame counter:
  - cnt counts 0..PERIOD_CYC-1, then wraps to 0.
  - The cycle with cnt==PERIOD_CYC-1 is the boundary cycle. The first frame after reset release starts at cnt=0 with en_lat=0, so it is silent.
- Boundary update, per channel, in the boundary cycle only:
  - tgt = min(angle_in_i, MAX_ANGLE); diff = tgt - cur_angle (signed).
  - If ch_en_i=0: cur_angle holds and en_lat_i<=0.
  - Else if SLEW_DEG==0 or |diff|<=SLEW_DEG: cur_angle<=tgt.
  - Else: cur_angle<=cur_angle ± SLEW_DEG, toward tgt.
  - width_lat<=MIN_WIDTH+new_cur_angle*STEP_CYC; en_lat_i<=ch_en_i.
  - at_target_i<=(new_cur_angle==tgt).
- Sampling: angle_in and ch_en changes between boundaries have no effect until the next boundary. Pulses are therefore never glitched mid-frame.
- PWM output:
  - servo_pwm_i is high in exactly the cycles where cnt<width_lat_i and en_lat_i=1.
  - Result: width_lat_i consecutive high cycles per PERIOD_CYC cycles.
  - The rising edge coincides with frame_start. Implementation compares against next-state cnt/latches to stay registered and aligned.
- Disable mid-pulse: the pulse in progress completes; subsequent frames are low. Re-enable resumes from the held cur_angle.
- frame_start: high in exactly the cycle with cnt==0, except the first cycle after reset release, where it stays 0.
- Arithmetic:
  - Width is computed in CNT_W bits.
  - Elaboration check: MIN_WIDTH+MAX_ANGLE*STEP_CYC < PERIOD_CYC, and HOME_ANGLE<=MAX_ANGLE.
  - The clamp handles angle_in 181..255.
  - Slew never overshoots the target.

Decomposition:
- Shared package servo_pkg:
  - ANGLE_W=8.
  - Default timing constants (PERIOD_CYC, MIN_WIDTH, STEP_CYC, MAX_ANGLE).
  - Function angle_to_width().
- Sub-module servo_slew_channel, one per channel via generate:
  - Inputs: clamped target, enable, boundary strobe, cnt_next.
  - Holds cur_angle, width_lat, en_lat.
  - Drives pwm and at_target.
- The top level owns the frame counter, frame_start, and unpacking of angle_in.

Test Plan:
Bench parameters: PERIOD_CYC=1000, MIN_WIDTH=100, STEP_CYC=2, SLEW_DEG=10, HOME_ANGLE=90, N_CH=4.
1. Reset release, all ch_en=1, angle_in=90 → first frame all pwm low; from frame 2, each pwm high 280 cycles per 1000; rising edge aligned with frame_start; at_target=1.
2. ch0 target 0 from home 90 → ch0 high times 260,240,…,100 on successive frames; at_target[0] rises at the boundary producing width 100 and stays high.
3. SLEW_DEG=0 build, ch1 angle_in=200 → next frame width 460 (clamped to 180°); at_target[1]=1 at the same boundary.
4. Change ch2 angle_in from 90 to 100 at cnt=50 (mid-pulse) → current pulse stays 280; next frame 300.
5. Deassert ch_en[3] at cnt=150 → current pulse completes at 280 cycles; following frames low. Re-enable → width resumes at 280.
6. Assert rst at cnt=200 → all servo_pwm=0 in the same cycle; after release, cur_angles are back to 90 and the first frame is silent.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants, types and helpers for the multi-channel servo PWM block.
package servo_pkg;

    localparam int ANGLE_W = 8;

    // Default frame geometry: 20 ms frame at 50 MHz, 0.6 ms .. 2.4 ms pulse.
    localparam int DEF_PERIOD_CYC = 1000000;
    localparam int DEF_MIN_WIDTH  = 30000;
    localparam int DEF_STEP_CYC   = 500;
    localparam int DEF_MAX_ANGLE  = 180;

    typedef logic [ANGLE_W-1:0] angle_t;

    // Pulse width in clock cycles for a given angle.
    function automatic logic [31:0] angle_to_width(
        input angle_t      angle,
        input int unsigned min_width,
        input int unsigned step_cyc
    );
        return min_width + 32'(angle) * step_cyc;
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: slew-limited current angle, frame-latched pulse width
// and enable, registered PWM output and at-target flag.
module servo_slew_channel
    import servo_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter int STEP_CYC   = DEF_STEP_CYC,
    parameter int SLEW_DEG   = 2,
    parameter int HOME_ANGLE = 90
) (
    input  logic             clk,
    input  logic             rst,
    input  angle_t           i_tgt,
    input  logic             i_en,
    input  logic             i_boundary,
    input  logic [CNT_W-1:0] i_cnt_next,
    output logic             o_pwm,
    output logic             o_at_target
);

    localparam angle_t           HOME_ANG   = ANGLE_W'(HOME_ANGLE);
    localparam logic [CNT_W-1:0] HOME_WIDTH = CNT_W'(angle_to_width(HOME_ANG, MIN_WIDTH, STEP_CYC));
    localparam logic [ANGLE_W:0] SLEW_MAG   = (ANGLE_W+1)'(SLEW_DEG);
    localparam angle_t           SLEW_ANG   = ANGLE_W'(SLEW_DEG);

    angle_t           r_cur_angle;
    logic [CNT_W-1:0] r_width_lat;
    logic             r_en_lat;
    logic             r_pwm;
    logic             r_at_target;

    logic signed [ANGLE_W:0] w_diff;
    logic [ANGLE_W:0]        w_abs_diff;
    angle_t                  w_step_angle;
    angle_t                  w_new_angle;
    angle_t                  w_angle_next;
    logic [CNT_W-1:0]        w_width_next;
    logic                    w_en_next;

    // Next-state of angle, width and enable; only the boundary cycle may change them.
    always_comb begin
        w_diff     = $signed({1'b0, i_tgt}) - $signed({1'b0, r_cur_angle});
        w_abs_diff = w_diff[ANGLE_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
        // A step of exactly SLEW_DEG or less lands on the target, so no overshoot.
        if (SLEW_DEG == 0 || w_abs_diff <= SLEW_MAG) begin
            w_step_angle = i_tgt;
        end else if (w_diff[ANGLE_W]) begin
            w_step_angle = r_cur_angle - SLEW_ANG;
        end else begin
            w_step_angle = r_cur_angle + SLEW_ANG;
        end
        w_new_angle  = i_en ? w_step_angle : r_cur_angle;
        w_angle_next = i_boundary ? w_new_angle : r_cur_angle;
        w_en_next    = i_boundary ? i_en : r_en_lat;
        w_width_next = i_boundary ? CNT_W'(angle_to_width(w_new_angle, MIN_WIDTH, STEP_CYC))
                                  : r_width_lat;
    end

    // Channel state; PWM compares next-state counter and latches so the
    // registered output rises together with frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_angle <= HOME_ANG;
            r_width_lat <= HOME_WIDTH;
            r_en_lat    <= 1'b0;
            r_pwm       <= 1'b0;
            r_at_target <= 1'b0;
        end else begin
            r_cur_angle <= w_angle_next;
            r_width_lat <= w_width_next;
            r_en_lat    <= w_en_next;
            r_pwm       <= w_en_next && (i_cnt_next < w_width_next);
            if (i_boundary) begin
                r_at_target <= (w_new_angle == i_tgt);
            end
        end
    end

    assign o_pwm       = r_pwm;
    assign o_at_target = r_at_target;

endmodule

// File: rtl/servo_pwm_multi_slew.sv
// N-channel hobby-servo PWM generator with a shared frame counter and
// per-channel slew-limited angle tracking.
module servo_pwm_multi_slew
    import servo_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int PERIOD_CYC = DEF_PERIOD_CYC,
    parameter int MIN_WIDTH  = DEF_MIN_WIDTH,
    parameter int STEP_CYC   = DEF_STEP_CYC,
    parameter int MAX_ANGLE  = DEF_MAX_ANGLE,
    parameter int SLEW_DEG   = 2,
    parameter int HOME_ANGLE = 90,
    parameter int CNT_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ANGLE_W*N_CH-1:0] angle_in,
    input  logic [N_CH-1:0]         ch_en,
    output logic [N_CH-1:0]         servo_pwm,
    output logic                    frame_start,
    output logic [N_CH-1:0]         at_target
);

    if (MIN_WIDTH + MAX_ANGLE * STEP_CYC >= PERIOD_CYC) begin : g_bad_width
        $error("servo_pwm_multi_slew: maximum pulse width does not fit in the frame");
    end
    if (HOME_ANGLE > MAX_ANGLE) begin : g_bad_home
        $error("servo_pwm_multi_slew: HOME_ANGLE exceeds MAX_ANGLE");
    end
    if (longint'(PERIOD_CYC - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("servo_pwm_multi_slew: CNT_W too narrow for PERIOD_CYC");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);

    // Saturate a raw command byte to the mechanical range.
    function automatic angle_t clamp_angle(input angle_t a);
        return (int'(a) > MAX_ANGLE) ? ANGLE_W'(MAX_ANGLE) : a;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_start;
    logic             w_boundary;
    logic [CNT_W-1:0] w_cnt_next;

    assign w_boundary = (r_cnt == LAST_CNT);
    assign w_cnt_next = w_boundary ? '0 : r_cnt + CNT_W'(1);

    // Shared frame counter; frame_start marks cnt==0 except right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_frame_start <= w_boundary;
        end
    end

    assign frame_start = r_frame_start;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        angle_t w_tgt;
        assign w_tgt = clamp_angle(angle_in[g*ANGLE_W +: ANGLE_W]);

        servo_slew_channel #(
            .CNT_W      (CNT_W),
            .MIN_WIDTH  (MIN_WIDTH),
            .STEP_CYC   (STEP_CYC),
            .SLEW_DEG   (SLEW_DEG),
            .HOME_ANGLE (HOME_ANGLE)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .i_tgt       (w_tgt),
            .i_en        (ch_en[g]),
            .i_boundary  (w_boundary),
            .i_cnt_next  (w_cnt_next),
            .o_pwm       (servo_pwm[g]),
            .o_at_target (at_target[g])
        );
    end

endmodule
